// File: rtl/sequence_counter.sv
// Timing-state generator: 4-bit sequence count SC decoded into one-hot timing vector T.
// Define SC_BIN_OUT_EN to add the binary count output CNT.
module sequence_counter #(
    parameter  int STATES = 16,
    localparam int CW     = $clog2(STATES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CLR,
    input  logic              INR,
    input  logic              S,
`ifdef SC_BIN_OUT_EN
    output logic [CW-1:0]     CNT,
`endif
    output logic [STATES-1:0] T
);

    localparam logic [STATES-1:0] T_ONE = STATES'(1);
    localparam logic [CW-1:0]     SC_ONE = CW'(1);

    // Power-up value keeps simulation at T[0] even if rst is never pulsed.
    logic [CW-1:0] r_sc = '0;

    // STATES is a power of two, so the natural CW-bit rollover is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc <= '0;
        end else if (S) begin
            if (CLR) begin
                r_sc <= '0;
            end else if (INR) begin
                r_sc <= r_sc + SC_ONE;
            end
        end
    end

    // Decode from the register only: no path from CLR/INR/S back to T.
    assign T = T_ONE << r_sc;

`ifdef SC_BIN_OUT_EN
    assign CNT = r_sc;
`endif

endmodule

// File: tb/tb_sequence_counter.sv
// Self-checking bench for sequence_counter: directed test-plan scenarios plus
// randomized control stimulus compared against a step-index reference model.
module tb_sequence_counter;

    localparam int STATES = 16;
    localparam int CW     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              CLR = 1'b0;
    logic              INR = 1'b0;
    logic              S   = 1'b0;
    logic [STATES-1:0] T;
`ifdef SC_BIN_OUT_EN
    logic [CW-1:0]     CNT;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_step = 0;

    sequence_counter #(.STATES(STATES)) dut (
        .clk (clk),
        .rst (rst),
        .CLR (CLR),
        .INR (INR),
        .S   (S),
`ifdef SC_BIN_OUT_EN
        .CNT (CNT),
`endif
        .T   (T)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] timing_vec(input int k);
        logic [15:0] v;
        v = '0;
        for (int b = 0; b < STATES; b++) begin
            if (b == k) v[b] = 1'b1;
        end
        return v;
    endfunction

    // One clock edge with the given controls, then compare against the model.
    task automatic step(input logic r, input logic c, input logic i, input logic s, input string tag);
        rst = r; CLR = c; INR = i; S = s;
        @(posedge clk);
        #1;
        if (r)                exp_step = 0;
        else if (!s)          exp_step = exp_step;
        else if (c)           exp_step = 0;
        else if (i)           exp_step = (exp_step + 1) % STATES;
        check(tag, 16'(T), timing_vec(exp_step));
        check({tag, "_onehot"}, 16'($countones(T)), 16'd1);
`ifdef SC_BIN_OUT_EN
        check({tag, "_cnt"}, 16'(CNT), 16'(exp_step));
`endif
    endtask

    initial begin
        #1;
        check("powerup_t", 16'(T), 16'h0001);

        // Reset with INR and S active
        step(1'b1, 1'b0, 1'b1, 1'b1, "reset");
        check("reset_const", 16'(T), 16'h0001);

        // Count through all states and wrap
        for (int k = 1; k <= STATES; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, "count");
            check("count_const", 16'(T), (k == STATES) ? 16'h0001 : (16'h0001 << k));
        end

        // CLR wins over INR at T = 0x0020
        step(1'b1, 1'b0, 1'b0, 1'b1, "reset2");
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b1, "to_t5");
        check("at_t5", 16'(T), 16'h0020);
        step(1'b0, 1'b1, 1'b1, 1'b1, "clr_prio");
        check("clr_prio_const", 16'(T), 16'h0001);

        // Halt at T = 0x0008 while INR/CLR pulse, then resume
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1, "to_t3");
        check("at_t3", 16'(T), 16'h0008);
        step(1'b0, 1'b0, 1'b1, 1'b0, "halt_inr");
        step(1'b0, 1'b1, 1'b0, 1'b0, "halt_clr");
        step(1'b0, 1'b1, 1'b1, 1'b0, "halt_both");
        check("halt_const", 16'(T), 16'h0008);
        step(1'b0, 1'b0, 1'b1, 1'b1, "resume");
        check("resume_const", 16'(T), 16'h0010);

        // Reset while halted
        step(1'b1, 1'b0, 1'b0, 1'b1, "reset3");
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1, "to_t3b");
        step(1'b0, 1'b0, 1'b1, 1'b0, "halt2");
        step(1'b1, 1'b0, 1'b1, 1'b0, "rst_halted");
        check("rst_halted_const", 16'(T), 16'h0001);

        // Fetch/execute: three increments then clear
        step(1'b0, 1'b0, 1'b1, 1'b1, "fetch1");
        step(1'b0, 1'b0, 1'b1, 1'b1, "fetch2");
        step(1'b0, 1'b0, 1'b1, 1'b1, "fetch3");
        check("fetch_const", 16'(T), 16'h0008);
        step(1'b0, 1'b1, 1'b0, 1'b1, "exec_clr");
        check("exec_clr_const", 16'(T), 16'h0001);

        // Randomized controls; rst rare, S mostly high
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) != 0),
                 "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
